jt053246_objdma: RTL and testbench
==================================

Name: jt053246_objdma

Overview:
- Object-table DMA engine for the K053246/K053247 (and K053244/5) sprite generator.
- Copies sprite attribute RAM from external object RAM into two internal 16-bit line-buffer RAMs (even/odd word banks) that the sprite scanner reads.
- Sits between the external object RAM port and the sprite table scanner inside the sprite block.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pxl2_cen  in  1  clock enable, twice pixel rate; the DMA advances only on these cycles
- mode8  in  1  8-bit CPU mode flag (cfg bit 2)
- dma_en  in  1  DMA enable (cfg bit 4); gates the frame-start trigger in K053246 mode
- dma_trig  in  1  explicit DMA start pulse, used in K053244 mode
- k44_en  in  1  1 = K053244/5 mode (128 objects); 0 = K053246/7 mode (256 objects)
- simson  in  1  game-specific byte-order selector
- hs  in  1  horizontal sync (unused by the datapath; present for interface compatibility)
- vs  in  1  vertical sync; its rising edge marks frame start
- dma_addr  out  13  external object RAM word address [13:1]
- dma_data  in  16  external object RAM read data
- dma_bsy  out  1  high while a transfer is running
- dma_wel  out  1  write strobe, even bank
- dma_weh  out  1  write strobe, odd bank
- dma_wr_addr  out  11  buffer word address [11:1]
- dma_din  out  16  buffer write data
- flicker  out  1  debug frame toggle

Behaviour:
- All registers update on posedge clk; state changes only when pxl2_cen=1, except reset.
- Reset values: dma_bsy=0, dma_addr=0, dma_wr_addr=0, dma_wel=0, dma_weh=0, dma_din=0, flicker=0. Edge-detect register vs_l=0.
- vs edge detect: vs_l is sampled on pxl2_cen. A rising edge is vs=1 and vs_l=0.
- Start conditions, evaluated only when idle (dma_bsy=0):
  - k44_en=0: vs rising edge with dma_en=1.
  - k44_en=1: dma_trig=1 on a pxl2_cen cycle; vs does not start a transfer.
  - A start request while busy is ignored; no queuing.
- Transfer length: 2048 words when k44_en=0, 1024 words when k44_en=1. Source words run 0..N-1; dma_addr[13:12] is always 0.
- State IDLE -> READ on start: dma_bsy=1, dma_addr=0.
- READ, on each pxl2_cen:
  - dma_addr increments.
  - The data on dma_data for the previous address is written with dma_wr_addr = previous dma_addr[11:1].
  - External RAM read latency is one pxl2_cen period.
- Bank strobes: dma_wel=1 when dma_wr_addr[1]=0; dma_weh=1 when dma_wr_addr[1]=1.
  - Each strobe is a single clk-cycle pulse coinciding with pxl2_cen; low otherwise.
  - The buffer RAMs are addressed by dma_wr_addr[11:2].
- Object layout: 8 words per object. Words 0,2,4,6 go to the even bank; words 1,3,5,7 go to the odd bank.
- Byte order:
  - swap = mode8 XOR simson.
  - swap=1: dma_din = {dma_data[7:0], dma_data[15:8]}.
  - swap=0: dma_din = dma_data.
- Completion:
  - After the last word (N-1) is written, return to IDLE and clear dma_bsy.
  - Total busy time is N+1 pxl2_cen ticks.
  - dma_addr holds its last value while idle.
- Clearing dma_en mid-transfer does not abort the transfer.
- Reset mid-transfer aborts immediately; no further write strobes.

Optional Feature:
- Macro JT053246_DMA_FLICKER_EN.
- Defined: flicker toggles on every vs rising edge (pxl2_cen-qualified), independent of dma_en.
- Undefined: flicker is constant 0.

Test Plan:
- Reset, then idle with vs toggling and dma_en=0 -> dma_bsy stays 0; no dma_wel/dma_weh pulses.
- k44_en=0, dma_en=1, vs rising; external RAM returns data = word address -> dma_bsy high for 2049 pxl2_cen ticks; 1024 dma_wel and 1024 dma_weh pulses; even bank entry 5 = 0x000A, odd bank entry 5 = 0x000B.
- k44_en=1, dma_trig pulse -> 1024 words copied, dma_bsy low afterwards; vs rising edges alone start nothing.
- simson=1, mode8=0, dma_data=0x1234 -> dma_din=0x3412. mode8=1 and simson=1 -> dma_din=0x1234.
- dma_trig asserted again mid-transfer -> ignored; total word count unchanged. rst asserted mid-transfer -> dma_bsy=0 the next clk.
- JT053246_DMA_FLICKER_EN defined, 3 vs rising edges -> flicker goes 0->1->0->1. Undefined -> flicker stays 0.

Source files
------------

// File: rtl/jt053246_objdma.sv
// Object-table DMA: copies external sprite attribute RAM into the even/odd word line-buffer banks.
// Optional build macro JT053246_DMA_FLICKER_EN enables the per-frame flicker toggle output.
module jt053246_objdma (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl2_cen,
    input  logic        mode8,
    input  logic        dma_en,
    input  logic        dma_trig,
    input  logic        k44_en,
    input  logic        simson,
    input  logic        hs,
    input  logic        vs,
    output logic [12:0] dma_addr,
    input  logic [15:0] dma_data,
    output logic        dma_bsy,
    output logic        dma_wel,
    output logic        dma_weh,
    output logic [10:0] dma_wr_addr,
    output logic [15:0] dma_din,
    output logic        flicker
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [15:0] din_q, din_d;
    logic        wel_q, wel_d;
    logic        weh_q, weh_d;
    logic        bsy_q, bsy_d;
    logic        vs_l_q, vs_l_d;

    logic        vs_rise;
    logic        start;
    logic        swap;
    logic [12:0] last_addr;
    logic        unused_hs;

    assign unused_hs = hs;
    assign vs_rise   = pxl2_cen & vs & ~vs_l_q;
    // K053244 mode is started by the CPU trigger only; K053246 mode by frame start
    assign start     = k44_en ? dma_trig : (vs_rise & dma_en);
    assign swap      = mode8 ^ simson;
    assign last_addr = k44_en ? 13'd1023 : 13'd2047;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        din_d     = din_q;
        wel_d     = 1'b0;
        weh_d     = 1'b0;
        vs_l_d    = vs_l_q;
        if (pxl2_cen) begin
            vs_l_d = vs;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_READ;
                        addr_d  = 13'd0;
                    end
                end
                ST_READ: begin
                    // dma_data now holds the word for the address presented last tick
                    wr_addr_d = addr_q[10:0];
                    din_d     = swap ? {dma_data[7:0], dma_data[15:8]} : dma_data;
                    wel_d     = ~addr_q[0];
                    weh_d     = addr_q[0];
                    if (addr_q == last_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + 13'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        bsy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 13'd0;
            wr_addr_q <= 11'd0;
            din_q     <= 16'd0;
            wel_q     <= 1'b0;
            weh_q     <= 1'b0;
            bsy_q     <= 1'b0;
            vs_l_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            din_q     <= din_d;
            wel_q     <= wel_d;
            weh_q     <= weh_d;
            bsy_q     <= bsy_d;
            vs_l_q    <= vs_l_d;
        end
    end

`ifdef JT053246_DMA_FLICKER_EN
    logic flick_q, flick_d;

    assign flick_d = vs_rise ? ~flick_q : flick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flick_q <= 1'b0;
        end else begin
            flick_q <= flick_d;
        end
    end

    assign flicker = flick_q;
`else
    assign flicker = 1'b0;
`endif

    assign dma_addr    = addr_q;
    assign dma_wr_addr = wr_addr_q;
    assign dma_din     = din_q;
    assign dma_wel     = wel_q;
    assign dma_weh     = weh_q;
    assign dma_bsy     = bsy_q;

endmodule

// File: tb/tb_jt053246_objdma.sv
// Directed bench for jt053246_objdma: reset, both transfer modes, byte swap, abort and flicker.
module tb_jt053246_objdma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl2_cen = 1'b0;
    logic        mode8 = 1'b0;
    logic        dma_en = 1'b0;
    logic        dma_trig = 1'b0;
    logic        k44_en = 1'b0;
    logic        simson = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [12:0] dma_addr;
    logic [15:0] dma_data;
    logic        dma_bsy;
    logic        dma_wel;
    logic        dma_weh;
    logic [10:0] dma_wr_addr;
    logic [15:0] dma_din;
    logic        flicker;

    logic        fixed_en = 1'b0;
    logic [15:0] fixed_val = 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int bsy_cycles = 0;
    int wel_cnt = 0;
    int weh_cnt = 0;
    int addr_hi = 0;
    logic [15:0] even_mem [1024];
    logic [15:0] odd_mem  [1024];

    assign dma_data = fixed_en ? fixed_val : {3'b000, dma_addr};

    jt053246_objdma dut (
        .clk         (clk),
        .rst         (rst),
        .pxl2_cen    (pxl2_cen),
        .mode8       (mode8),
        .dma_en      (dma_en),
        .dma_trig    (dma_trig),
        .k44_en      (k44_en),
        .simson      (simson),
        .hs          (hs),
        .vs          (vs),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_bsy     (dma_bsy),
        .dma_wel     (dma_wel),
        .dma_weh     (dma_weh),
        .dma_wr_addr (dma_wr_addr),
        .dma_din     (dma_din),
        .flicker     (flicker)
    );

    initial forever #5 clk = ~clk;

    // Observer: counts busy cycles and strobes, mirrors bank writes, and paces pxl2_cen.
    initial forever begin
        @(negedge clk);
        if (dma_bsy) bsy_cycles++;
        if (dma_addr[12:11] != 2'b00) addr_hi++;
        if (dma_wel) begin
            wel_cnt++;
            even_mem[dma_wr_addr[10:1]] = dma_din;
        end
        if (dma_weh) begin
            weh_cnt++;
            odd_mem[dma_wr_addr[10:1]] = dma_din;
        end
        pxl2_cen = ~pxl2_cen;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        bsy_cycles = 0;
        wel_cnt = 0;
        weh_cnt = 0;
        addr_hi = 0;
    endtask

    task automatic pulse_vs();
        vs = 1'b1;
        repeat (6) @(negedge clk);
        vs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_trig();
        dma_trig = 1'b1;
        repeat (2) @(negedge clk);
        dma_trig = 1'b0;
    endtask

    task automatic wait_bsy(input logic val, input int limit, input string tag);
        int n = 0;
        while (dma_bsy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, dma_bsy}, {31'd0, val});
    endtask

    task automatic wait_strobe(input int limit);
        int n = 0;
        while (!(dma_wel === 1'b1 || dma_weh === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("strobe_timeout", {31'd0, (dma_wel | dma_weh)}, 32'd1);
    endtask

    task automatic abort_check();
        rst = 1'b1;
        @(negedge clk);
        check("abort_bsy", {31'd0, dma_bsy}, 32'd0);
        check("abort_strobes", {30'd0, dma_wel, dma_weh}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        repeat (20) @(negedge clk);
        check("post_abort_strobes", wel_cnt + weh_cnt, 32'd0);
        check("post_abort_bsy", bsy_cycles, 32'd0);
    endtask

    logic [31:0] flick_exp;

    initial begin
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bsy", {31'd0, dma_bsy}, 32'd0);
        check("rst_addr", {19'd0, dma_addr}, 32'd0);
        check("rst_wr_addr", {21'd0, dma_wr_addr}, 32'd0);
        check("rst_strobes", {30'd0, dma_wel, dma_weh}, 32'd0);
        check("rst_din", {16'd0, dma_din}, 32'd0);
        check("rst_flicker", {31'd0, flicker}, 32'd0);

        // Idle with dma_en low: vs edges must not start anything
        clear_counts();
        for (int i = 1; i <= 3; i++) begin
            pulse_vs();
`ifdef JT053246_DMA_FLICKER_EN
            flick_exp = (i % 2 == 1) ? 32'd1 : 32'd0;
`else
            flick_exp = 32'd0;
`endif
            check("flicker_edge", {31'd0, flicker}, flick_exp);
        end
        check("idle_bsy_cycles", bsy_cycles, 32'd0);
        check("idle_strobes", wel_cnt + weh_cnt, 32'd0);

        // K053246 mode, full 2048-word copy started by vs; dma_en dropped mid-way
        dma_en = 1'b1;
        vs = 1'b1;
        wait_bsy(1'b1, 20, "k46_start");
        vs = 1'b0;
        repeat (50) @(negedge clk);
        dma_en = 1'b0;
        wait_bsy(1'b0, 5000, "k46_done");
        repeat (4) @(negedge clk);
        check("k46_bsy_cycles", bsy_cycles, 32'd4098);
        check("k46_wel_cnt", wel_cnt, 32'd1024);
        check("k46_weh_cnt", weh_cnt, 32'd1024);
        check("k46_even5", {16'd0, even_mem[5]}, 32'h000A);
        check("k46_odd5", {16'd0, odd_mem[5]}, 32'h000B);
        check("k46_even_last", {16'd0, even_mem[1023]}, 32'h07FE);
        check("k46_odd_last", {16'd0, odd_mem[1023]}, 32'h07FF);
        check("k46_addr_hold", {19'd0, dma_addr}, 32'h07FF);
        check("k46_addr_hi", addr_hi, 32'd0);

        // K053244 mode: vs alone does nothing, trigger copies 1024 words, retrigger ignored
        for (int i = 0; i < 1024; i++) begin
            even_mem[i] = 16'hDEAD;
            odd_mem[i] = 16'hDEAD;
        end
        k44_en = 1'b1;
        dma_en = 1'b1;
        clear_counts();
        pulse_vs();
        repeat (10) @(negedge clk);
        check("k44_vs_nostart", bsy_cycles, 32'd0);
        pulse_trig();
        wait_bsy(1'b1, 20, "k44_start");
        repeat (200) @(negedge clk);
        pulse_trig();
        wait_bsy(1'b0, 3000, "k44_done");
        repeat (4) @(negedge clk);
        check("k44_bsy_cycles", bsy_cycles, 32'd2050);
        check("k44_wel_cnt", wel_cnt, 32'd512);
        check("k44_weh_cnt", weh_cnt, 32'd512);
        check("k44_even5", {16'd0, even_mem[5]}, 32'h000A);
        check("k44_odd_last", {16'd0, odd_mem[511]}, 32'h03FF);
        check("k44_even_unwritten", {16'd0, even_mem[512]}, 32'hDEAD);
        check("k44_addr_hold", {19'd0, dma_addr}, 32'h03FF);

        // Byte order, each case aborted by reset mid-transfer
        fixed_en = 1'b1;
        fixed_val = 16'h1234;
        simson = 1'b1;
        mode8 = 1'b0;
        pulse_trig();
        wait_bsy(1'b1, 20, "swap1_start");
        wait_strobe(20);
        check("swap_simson", {16'd0, dma_din}, 32'h3412);
        abort_check();

        mode8 = 1'b1;
        simson = 1'b1;
        pulse_trig();
        wait_bsy(1'b1, 20, "swap2_start");
        wait_strobe(20);
        check("swap_both", {16'd0, dma_din}, 32'h1234);
        abort_check();

        mode8 = 1'b1;
        simson = 1'b0;
        pulse_trig();
        wait_bsy(1'b1, 20, "swap3_start");
        wait_strobe(20);
        check("swap_mode8", {16'd0, dma_din}, 32'h3412);
        abort_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
